ascon_cipher_rx: RTL

//  Receiving end of the Ascon-128 encryptor output interface (cipher_valid/cipher/end/tag).
//  - Buffers up to NB_BLOC 128-bit ciphertext blocks of one message.
//  - Captures the final tag and compares it against a reference tag loaded at start.
//  - Releases the buffered blocks downstream in order over a valid/ready handshake.
//  - Sits between the ascon top level and the host/DMA side of the design.

---
 rtl/ascon_pack.sv | 16 +
 rtl/ascon_rx_buffer.sv | 31 +++
 rtl/ascon_cipher_rx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// Shared types for the Ascon-128 ciphertext receiver: FSM states, block type, tag width.
package ascon_pack;

    localparam int TAG_WIDTH = 128;

    typedef logic [127:0] type_block;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        DRAIN,
        ERROR
    } rx_state_t;

endpackage

// File: rtl/ascon_rx_buffer.sv
// NB_BLOC x 128-bit register file: one write port, asynchronous read, synchronous clear.
module ascon_rx_buffer
    import ascon_pack::*;
#(
    parameter int NB_BLOC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       we,
    input  logic [$clog2(NB_BLOC)-1:0] waddr,
    input  type_block                  wdata,
    input  logic [$clog2(NB_BLOC)-1:0] raddr,
    output type_block                  rdata
);

    type_block mem [NB_BLOC];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int unsigned i = 0; i < NB_BLOC; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ascon_cipher_rx.sv
// Ascon-128 ciphertext receiver: buffers one message, checks its tag, drains blocks downstream.
// Optional build macro ASCON_RX_TAG_GATE_EN: withhold (and wipe) ciphertext on tag mismatch.
module ascon_cipher_rx
    import ascon_pack::*;
#(
    parameter int NB_BLOC = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [TAG_WIDTH-1:0]       exp_tag_i,
    input  logic                       cipher_valid_i,
    input  type_block                  cipher_i,
    input  logic                       end_i,
    input  logic [TAG_WIDTH-1:0]       tag_i,
    output logic                       blk_valid_o,
    input  logic                       blk_ready_i,
    output type_block                  blk_data_o,
    output logic [$clog2(NB_BLOC)-1:0] blk_idx_o,
    output logic                       blk_last_o,
    output logic                       tag_ok_o,
    output logic                       tag_err_o,
    output logic                       ovf_o,
    output logic                       done_o
);

    localparam int CW = $clog2(NB_BLOC + 1);
    localparam int IW = $clog2(NB_BLOC);
    localparam logic [CW-1:0] FULL = CW'(NB_BLOC);

    rx_state_t              state;
    logic [CW-1:0]          wr_cnt;
    logic [CW-1:0]          rd_cnt;
    logic [CW-1:0]          rd_nxt;
    logic [TAG_WIDTH-1:0]   exp_tag_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   diff;
    logic                   skip_drain;
    logic                   buf_we;
    logic                   buf_clr;
    type_block              rd_data;

    // Full-width OR reduction; no early exit on the first differing bit.
    assign diff   = |(tag_q ^ exp_tag_q);
    assign rd_nxt = rd_cnt + CW'(1);

    always_comb begin
        buf_we     = (state == COLLECT) && cipher_valid_i && (wr_cnt != FULL) && !start_i;
        buf_clr    = start_i;
        skip_drain = (wr_cnt == '0);
`ifdef ASCON_RX_TAG_GATE_EN
        if (state == CHECK && diff) begin
            buf_clr    = 1'b1;
            skip_drain = 1'b1;
        end
`endif
    end

    ascon_rx_buffer #(
        .NB_BLOC (NB_BLOC)
    ) u_buffer (
        .clk   (clock_i),
        .rst   (reset_i),
        .clr   (buf_clr),
        .we    (buf_we),
        .waddr (wr_cnt[IW-1:0]),
        .wdata (cipher_i),
        .raddr (rd_cnt[IW-1:0]),
        .rdata (rd_data)
    );

    assign blk_data_o = blk_valid_o ? rd_data : '0;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            exp_tag_q   <= '0;
            tag_q       <= '0;
            blk_valid_o <= 1'b0;
            blk_idx_o   <= '0;
            blk_last_o  <= 1'b0;
            tag_ok_o    <= 1'b0;
            tag_err_o   <= 1'b0;
            ovf_o       <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start_i) begin
                state       <= COLLECT;
                wr_cnt      <= '0;
                rd_cnt      <= '0;
                exp_tag_q   <= exp_tag_i;
                tag_q       <= '0;
                blk_valid_o <= 1'b0;
                blk_idx_o   <= '0;
                blk_last_o  <= 1'b0;
                tag_ok_o    <= 1'b0;
                tag_err_o   <= 1'b0;
                ovf_o       <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    COLLECT: begin
                        if (cipher_valid_i && wr_cnt == FULL) begin
                            ovf_o <= 1'b1;
                            state <= ERROR;
                        end else begin
                            if (cipher_valid_i) begin
                                wr_cnt <= wr_cnt + CW'(1);
                            end
                            if (end_i) begin
                                tag_q <= tag_i;
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        tag_ok_o  <= ~diff;
                        tag_err_o <= diff;
                        if (skip_drain) begin
                            state  <= IDLE;
                            done_o <= 1'b1;
                        end else begin
                            state       <= DRAIN;
                            blk_valid_o <= 1'b1;
                            blk_idx_o   <= '0;
                            blk_last_o  <= (wr_cnt == CW'(1));
                        end
                    end
                    DRAIN: begin
                        if (blk_ready_i) begin
                            if (blk_last_o) begin
                                blk_valid_o <= 1'b0;
                                blk_idx_o   <= '0;
                                blk_last_o  <= 1'b0;
                                done_o      <= 1'b1;
                                state       <= IDLE;
                            end else begin
                                rd_cnt     <= rd_nxt;
                                blk_idx_o  <= rd_nxt[IW-1:0];
                                blk_last_o <= (rd_nxt == wr_cnt - CW'(1));
                            end
                        end
                    end
                    ERROR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
